// File: rtl/ldq_retire_ctrl_pkg.sv
// Shared sizing, FSM encoding and helpers for the LDQ pointer/retire controller.
package ldq_retire_ctrl_pkg;

  localparam int SIZE_LSQ       = 16;
  localparam int SIZE_LSQ_LOG   = 4;
  localparam int DISPATCH_WIDTH = 4;
  localparam int COMMIT_WIDTH   = 4;
  // Width of per-cycle load counts (dispatch group size and commit popcount, 0..4).
  localparam int CNT_W          = 3;

  typedef logic [SIZE_LSQ_LOG-1:0] ldq_ptr_t;
  typedef logic [SIZE_LSQ_LOG:0]   ldq_cnt_t;
  typedef logic [CNT_W-1:0]        ldq_num_t;

  localparam ldq_cnt_t LSQ_DEPTH  = ldq_cnt_t'(SIZE_LSQ);
  localparam ldq_cnt_t DISP_LIMIT = ldq_cnt_t'(DISPATCH_WIDTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ldq_state_e;

  // Zero-extend a small per-cycle count to occupancy width.
  function automatic ldq_cnt_t widen(input ldq_num_t n);
    return ldq_cnt_t'(n);
  endfunction

endpackage

// File: rtl/ldq_retire_idx_gen.sv
// Expands (head, accepted commit count) into per-slot retire valid/index pairs.
module ldq_retire_idx_gen
  import ldq_retire_ctrl_pkg::*;
(
  input  ldq_ptr_t                                     head,
  input  ldq_num_t                                     num,
  output logic [COMMIT_WIDTH-1:0]                      vld,
  output logic [COMMIT_WIDTH-1:0][SIZE_LSQ_LOG-1:0]    idx
);

  // Slot k frees head+k when k is below the commit count; indices wrap naturally.
  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
    assign vld[k] = (num > CNT_W'(k));
    assign idx[k] = vld[k] ? (head + SIZE_LSQ_LOG'(k)) : '0;
  end

endmodule

// File: rtl/ldq_retire_ctrl.sv
// LDQ head/tail/occupancy controller: dispatch allocation, in-order commit
// freeing with registered retire indices, and recovery flush.
module ldq_retire_ctrl
  import ldq_retire_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispatchValid_i,
  input  logic [CNT_W-1:0]        cntLdNew_i,
  input  logic                    commitLoad0_i,
  input  logic                    commitLoad1_i,
  input  logic                    commitLoad2_i,
  input  logic                    commitLoad3_i,
  input  logic                    recoverFlag_i,
  output logic [SIZE_LSQ_LOG-1:0] ldqHead_o,
  output logic [SIZE_LSQ_LOG-1:0] ldqTail_o,
  output logic [SIZE_LSQ_LOG:0]   ldqInsts_o,
  output logic                    ldqFull_o,
  output logic                    ldqEmpty_o,
  output logic                    ldqStall_o,
  output logic                    retireValid0_o,
  output logic                    retireValid1_o,
  output logic                    retireValid2_o,
  output logic                    retireValid3_o,
  output logic [SIZE_LSQ_LOG-1:0] retireIdx0_o,
  output logic [SIZE_LSQ_LOG-1:0] retireIdx1_o,
  output logic [SIZE_LSQ_LOG-1:0] retireIdx2_o,
  output logic [SIZE_LSQ_LOG-1:0] retireIdx3_o,
  output logic                    overflowErr_o,
  output logic                    underflowErr_o
);

  ldq_state_e state_q;
  ldq_ptr_t   head_q, tail_q;
  ldq_cnt_t   cnt_q;
  logic       ovf_q, unf_q;
  logic [COMMIT_WIDTH-1:0]                   rv_q;
  logic [COMMIT_WIDTH-1:0][SIZE_LSQ_LOG-1:0] ri_q;

  logic [COMMIT_WIDTH-1:0] commit_vec;
  ldq_num_t   commit_num, commit_acc, disp_acc;
  ldq_cnt_t   free_cnt;
  logic       commit_ok, disp_try, disp_ok, disp_ovf;
  ldq_ptr_t   head_nxt;
  logic [COMMIT_WIDTH-1:0]                   rv_nxt;
  logic [COMMIT_WIDTH-1:0][SIZE_LSQ_LOG-1:0] ri_nxt;

  assign commit_vec = {commitLoad3_i, commitLoad2_i, commitLoad1_i, commitLoad0_i};

  // Free space uses the registered count: same-cycle retirements are not credited.
  assign free_cnt = LSQ_DEPTH - cnt_q;

  // Commit popcount and dispatch/commit acceptance decisions.
  always_comb begin
    commit_num = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      commit_num = commit_num + ldq_num_t'(commit_vec[i]);
    commit_ok  = (widen(commit_num) <= cnt_q);
    commit_acc = commit_ok ? commit_num : '0;
    // A recovering cycle drops the dispatch group silently; FLUSH blocks it too.
    disp_try   = dispatchValid_i && (state_q == RUN) && !recoverFlag_i;
    disp_ok    = disp_try && (widen(cntLdNew_i) <= free_cnt);
    disp_ovf   = disp_try && (widen(cntLdNew_i) >  free_cnt);
    disp_acc   = disp_ok ? cntLdNew_i : '0;
    head_nxt   = head_q + ldq_ptr_t'(commit_acc);
  end

  ldq_retire_idx_gen u_idx_gen (
    .head (head_q),
    .num  (commit_acc),
    .vld  (rv_nxt),
    .idx  (ri_nxt)
  );

  // Recovery FSM: one FLUSH cycle per recoverFlag_i, back to RUN otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= recoverFlag_i ? FLUSH : RUN;
  end

  // Pointer, occupancy, retire output and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rv_q   <= '0;
      ri_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      head_q <= head_nxt;
      rv_q   <= rv_nxt;
      ri_q   <= ri_nxt;
      if (disp_ovf)   ovf_q <= 1'b1;
      if (!commit_ok) unf_q <= 1'b1;
      if (recoverFlag_i) begin
        // Everything younger than the committing loads is squashed.
        tail_q <= head_nxt;
        cnt_q  <= '0;
      end else begin
        tail_q <= tail_q + ldq_ptr_t'(disp_acc);
        cnt_q  <= cnt_q + widen(disp_acc) - widen(commit_acc);
      end
    end
  end

  assign ldqHead_o      = head_q;
  assign ldqTail_o      = tail_q;
  assign ldqInsts_o     = cnt_q;
  assign ldqFull_o      = (free_cnt < DISP_LIMIT);
  assign ldqEmpty_o     = (cnt_q == '0);
  assign ldqStall_o     = ldqFull_o || (state_q == FLUSH);
  assign overflowErr_o  = ovf_q;
  assign underflowErr_o = unf_q;
  assign retireValid0_o = rv_q[0];
  assign retireValid1_o = rv_q[1];
  assign retireValid2_o = rv_q[2];
  assign retireValid3_o = rv_q[3];
  assign retireIdx0_o   = ri_q[0];
  assign retireIdx1_o   = ri_q[1];
  assign retireIdx2_o   = ri_q[2];
  assign retireIdx3_o   = ri_q[3];

endmodule
